// File: rtl/hazard_ctrl_unit.sv
// Hazard detection, bubble insertion, branch-mispredict flush and EX forwarding
// for a 5-stage MIPS-style pipeline; owns the ID/EX, EX/MEM and MEM/WB control pipe.
module hazard_ctrl_unit #(
    parameter int CNT_W = 16,
    parameter int RF_AW = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       id_ctrl_i,
    input  logic             id_is_branch_i,
    input  logic [RF_AW-1:0] id_rs_i,
    input  logic [RF_AW-1:0] id_rt_i,
    input  logic [RF_AW-1:0] id_rd_i,
    input  logic             id_uses_rt_i,
    input  logic             predic_incorrect_i,
    input  logic             hold_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic [7:0]       ex_ctrl_o,
    output logic [RF_AW-1:0] ex_dest_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [3:0]       mem_ctrl_o,
    output logic [RF_AW-1:0] mem_dest_o,
    output logic             wb_regwrite_o,
    output logic             wb_memtoreg_o,
    output logic [RF_AW-1:0] wb_dest_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int REGWRITE = 7;
    localparam int MEMREAD  = 4;
    localparam int REGDST   = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [7:0]       ex_ctrl_q, ex_ctrl_d;
    logic [RF_AW-1:0] ex_dest_q, ex_dest_d;
    logic [RF_AW-1:0] ex_rs_q, ex_rs_d;
    logic [RF_AW-1:0] ex_rt_q, ex_rt_d;
    logic [3:0]       mem_ctrl_q;
    logic [RF_AW-1:0] mem_dest_q;
    logic             wb_regwrite_q;
    logic             wb_memtoreg_q;
    logic [RF_AW-1:0] wb_dest_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             ex_dest_nz, mem_dest_nz, wb_dest_nz;
    logic             load_use, br_ex, br_mem, br_hazard, stall;
    logic [RF_AW-1:0] id_dest;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // EX/MEM has priority; a load in EX/MEM has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_sel(input logic [RF_AW-1:0] src);
        if (mem_ctrl_q[3] && !mem_ctrl_q[0] && mem_dest_nz && (mem_dest_q == src))
            return FWD_MEM;
        if (wb_regwrite_q && wb_dest_nz && (wb_dest_q == src))
            return FWD_WB;
        return FWD_RF;
    endfunction

    // ---- ID stage: hazard detection against EX and MEM ----
    assign ex_dest_nz  = (ex_dest_q != '0);
    assign mem_dest_nz = (mem_dest_q != '0);
    assign wb_dest_nz  = (wb_dest_q != '0);
    assign id_dest     = id_ctrl_i[REGDST] ? id_rd_i : id_rt_i;

    assign load_use  = ex_ctrl_q[MEMREAD] && ex_dest_nz &&
                       ((ex_dest_q == id_rs_i) || (id_uses_rt_i && (ex_dest_q == id_rt_i)));
    assign br_ex     = ex_ctrl_q[REGWRITE] && ex_dest_nz &&
                       ((ex_dest_q == id_rs_i) || (ex_dest_q == id_rt_i));
    assign br_mem    = mem_ctrl_q[0] && mem_dest_nz &&
                       ((mem_dest_q == id_rs_i) || (mem_dest_q == id_rt_i));
    assign br_hazard = id_is_branch_i && (br_ex || br_mem);
    assign stall     = load_use || br_hazard;

    // Hold overrides everything; a mispredict seen during a stall is re-evaluated next cycle.
    assign pc_write_o   = !hold_i && !stall;
    assign ifid_write_o = !hold_i && !stall;
    assign ifid_flush_o = predic_incorrect_i && !stall && !hold_i;

    always_comb begin
        ex_ctrl_d   = id_ctrl_i;
        ex_dest_d   = id_dest;
        ex_rs_d     = id_rs_i;
        ex_rt_d     = id_rt_i;
        if (stall) begin
            ex_ctrl_d = 8'h00;
            ex_dest_d = '0;
            ex_rs_d   = '0;
            ex_rt_d   = '0;
        end
        stall_cnt_d = sat_inc(stall_cnt_q, stall);
        flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush_o);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_ctrl_q     <= '0;
            ex_dest_q     <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            mem_ctrl_q    <= '0;
            mem_dest_q    <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_dest_q     <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else if (!hold_i) begin
            // ---- ID -> EX ----
            ex_ctrl_q     <= ex_ctrl_d;
            ex_dest_q     <= ex_dest_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            // ---- EX -> MEM ----
            mem_ctrl_q    <= ex_ctrl_q[7:4];
            mem_dest_q    <= ex_dest_q;
            // ---- MEM -> WB ----
            wb_regwrite_q <= mem_ctrl_q[3];
            wb_memtoreg_q <= mem_ctrl_q[2];
            wb_dest_q     <= mem_dest_q;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // ---- EX stage: operand forwarding ----
    assign fwd_a_o = fwd_sel(ex_rs_q);
    assign fwd_b_o = fwd_sel(ex_rt_q);

    assign ex_ctrl_o     = ex_ctrl_q;
    assign ex_dest_o     = ex_dest_q;
    assign mem_ctrl_o    = mem_ctrl_q;
    assign mem_dest_o    = mem_dest_q;
    assign wb_regwrite_o = wb_regwrite_q;
    assign wb_memtoreg_o = wb_memtoreg_q;
    assign wb_dest_o     = wb_dest_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
